// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the click decoding path:
//   - level encodings (none / easy / medium / hard)
//   - grid dimension per level
//   - click type and decoder FSM state enumerations
// ----------------------------------------------------------------------------
package game_pkg;

    localparam logic [1:0] LVL_NONE   = 2'd0;
    localparam logic [1:0] LVL_EASY   = 2'd1;
    localparam logic [1:0] LVL_MEDIUM = 2'd2;
    localparam logic [1:0] LVL_HARD   = 2'd3;

    localparam logic [4:0] GRID_EASY   = 5'd8;
    localparam logic [4:0] GRID_MEDIUM = 5'd10;
    localparam logic [4:0] GRID_HARD   = 5'd16;

    typedef enum logic {
        CLICK_LEFT,
        CLICK_RIGHT
    } click_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CHECK,
        ISSUE
    } state_t;

endpackage

// File: rtl/cell_index_div.sv
// ----------------------------------------------------------------------------
// cell_index_div
// One axis of the pixel-to-cell divider. On start the remainder is loaded and
// the index cleared; afterwards one cell pitch is subtracted per cycle while
// the remainder still covers a full cell and the index is below button_num.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        load rem_in, clear idx
//   rem_in       pixel offset from the board origin
//   button_size  cell pitch in pixels
//   button_num   cells per row/column (idx saturates here)
//   idx          current cell index
//   done         remainder below one pitch, or idx saturated
// ----------------------------------------------------------------------------
module cell_index_div #(
    parameter int POS_W  = 12,
    parameter int SIZE_W = 8,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [POS_W-1:0]  rem_in,
    input  logic [SIZE_W-1:0] button_size,
    input  logic [IDX_W-1:0]  button_num,
    output logic [IDX_W-1:0]  idx,
    output logic              done
);

    logic [POS_W-1:0] r_rem;
    logic [IDX_W-1:0] r_idx;
    logic [POS_W-1:0] w_size_ext;
    logic             w_rem_ge;
    logic             w_sat;

    assign w_size_ext = {{(POS_W-SIZE_W){1'b0}}, button_size};
    assign w_rem_ge   = (r_rem >= w_size_ext);
    assign w_sat      = (r_idx >= button_num);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_idx <= '0;
        end else if (start) begin
            r_rem <= rem_in;
            r_idx <= '0;
        end else if (w_rem_ge && !w_sat) begin
            r_rem <= r_rem - w_size_ext;
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign idx  = r_idx;
    assign done = !w_rem_ge || w_sat;

endmodule

// File: rtl/click_action_decoder.sv
// ----------------------------------------------------------------------------
// click_action_decoder
// Turns mouse button edges into board cell indices and one-cycle action
// pulses for the redraw stage.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   level                      0 none, 1 easy, 2 medium, 3 hard
//   mouse_xpos/ypos            pointer position
//   mouse_left/right           button levels
//   board_xpos/ypos            board top-left corner
//   button_size, button_num    cell pitch and cells per row/column
//   mine_arr_easy/medium/hard  mine maps indexed [y][x]
//   game_won                   freezes click acceptance
//   symbol_ind_x/y             indices of the last issued click
//   defuse/mark_flag/explode   one-cycle action pulses
//   busy                       a click is being decoded
// ----------------------------------------------------------------------------
module click_action_decoder
    import game_pkg::*;
#(
    parameter int POS_W     = 12,
    parameter int SIZE_W    = 8,
    parameter int MAX_CELLS = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       level,
    input  logic [POS_W-1:0]                 mouse_xpos,
    input  logic [POS_W-1:0]                 mouse_ypos,
    input  logic                             mouse_left,
    input  logic                             mouse_right,
    input  logic [POS_W-1:0]                 board_xpos,
    input  logic [POS_W-1:0]                 board_ypos,
    input  logic [SIZE_W-1:0]                button_size,
    input  logic [$clog2(MAX_CELLS):0]       button_num,
    input  logic [7:0][7:0]                  mine_arr_easy,
    input  logic [9:0][9:0]                  mine_arr_medium,
    input  logic [15:0][15:0]                mine_arr_hard,
    input  logic                             game_won,
    output logic [$clog2(MAX_CELLS):0]       symbol_ind_x,
    output logic [$clog2(MAX_CELLS):0]       symbol_ind_y,
    output logic                             defuse,
    output logic                             mark_flag,
    output logic                             explode,
    output logic                             busy
);

    localparam int IDX_W = $clog2(MAX_CELLS) + 1;

    state_t           r_state;
    state_t           w_next;
    click_t           r_click_type;
    logic             r_left_prev;
    logic             r_right_prev;
    logic             r_lockout;
    logic             r_mine_bit;
    logic [IDX_W-1:0] r_sym_x;
    logic [IDX_W-1:0] r_sym_y;

    logic             w_left_edge;
    logic             w_right_edge;
    logic             w_in_bounds;
    logic             w_accept;
    logic [IDX_W-1:0] w_idx_x;
    logic [IDX_W-1:0] w_idx_y;
    logic             w_done_x;
    logic             w_done_y;
    logic             w_idx_oob;
    logic             w_calc_exit;
    logic             w_mine_bit;

    assign w_left_edge  = mouse_left  && !r_left_prev;
    assign w_right_edge = mouse_right && !r_right_prev;
    assign w_in_bounds  = (mouse_xpos >= board_xpos) && (mouse_ypos >= board_ypos);

    // Exactly one edge, only while idle; edges seen while busy are dropped.
    assign w_accept = (r_state == IDLE) && (w_left_edge ^ w_right_edge) &&
                      (level != LVL_NONE) && !r_lockout && !game_won && w_in_bounds;

    cell_index_div #(
        .POS_W  (POS_W),
        .SIZE_W (SIZE_W),
        .IDX_W  (IDX_W)
    ) u_div_x (
        .clk         (clk),
        .rst         (rst),
        .start       (w_accept),
        .rem_in      (mouse_xpos - board_xpos),
        .button_size (button_size),
        .button_num  (button_num),
        .idx         (w_idx_x),
        .done        (w_done_x)
    );

    cell_index_div #(
        .POS_W  (POS_W),
        .SIZE_W (SIZE_W),
        .IDX_W  (IDX_W)
    ) u_div_y (
        .clk         (clk),
        .rst         (rst),
        .start       (w_accept),
        .rem_in      (mouse_ypos - board_ypos),
        .button_size (button_size),
        .button_num  (button_num),
        .idx         (w_idx_y),
        .done        (w_done_y)
    );

    assign w_idx_oob   = (w_idx_x >= button_num) || (w_idx_y >= button_num);
    assign w_calc_exit = (w_done_x && w_done_y) || w_idx_oob;

    // Indices beyond the active level's grid read as safe rather than
    // wrapping into another cell.
    always_comb begin
        w_mine_bit = 1'b0;
        case (level)
            LVL_EASY:
                if (w_idx_x < GRID_EASY && w_idx_y < GRID_EASY)
                    w_mine_bit = mine_arr_easy[w_idx_y[2:0]][w_idx_x[2:0]];
            LVL_MEDIUM:
                if (w_idx_x < GRID_MEDIUM && w_idx_y < GRID_MEDIUM)
                    w_mine_bit = mine_arr_medium[w_idx_y[3:0]][w_idx_x[3:0]];
            LVL_HARD:
                if (w_idx_x < GRID_HARD && w_idx_y < GRID_HARD)
                    w_mine_bit = mine_arr_hard[w_idx_y[3:0]][w_idx_x[3:0]];
            default: w_mine_bit = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (w_calc_exit) w_next = CHECK;
            CHECK:   w_next = w_idx_oob ? IDLE : ISSUE;
            ISSUE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers. Indices and mine bit are captured on the CHECK to
    // ISSUE transition so they are already visible during the pulse cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left_prev  <= 1'b0;
            r_right_prev <= 1'b0;
            r_click_type <= CLICK_LEFT;
            r_lockout    <= 1'b0;
            r_mine_bit   <= 1'b0;
            r_sym_x      <= '0;
            r_sym_y      <= '0;
        end else begin
            r_left_prev  <= mouse_left;
            r_right_prev <= mouse_right;
            if (w_accept)
                r_click_type <= w_right_edge ? CLICK_RIGHT : CLICK_LEFT;
            if (r_state == CHECK && !w_idx_oob) begin
                r_mine_bit <= w_mine_bit;
                r_sym_x    <= w_idx_x;
                r_sym_y    <= w_idx_y;
            end
            if (r_state == ISSUE && r_click_type == CLICK_LEFT && r_mine_bit)
                r_lockout <= 1'b1;
        end
    end

    // Outputs
    always_comb begin
        defuse    = 1'b0;
        mark_flag = 1'b0;
        explode   = 1'b0;
        busy      = (r_state != IDLE);
        if (r_state == ISSUE) begin
            if (r_click_type == CLICK_RIGHT) mark_flag = 1'b1;
            else if (r_mine_bit)             explode   = 1'b1;
            else                             defuse    = 1'b1;
        end
    end

    assign symbol_ind_x = r_sym_x;
    assign symbol_ind_y = r_sym_y;

endmodule

// File: tb/tb_click_action_decoder.sv
// ----------------------------------------------------------------------------
// tb_click_action_decoder
// Directed clicks with hand-computed expected pulses queued at issue time; a
// monitor compares every pulse the decoder presents against the queue head.
// ----------------------------------------------------------------------------
module tb_click_action_decoder;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        level = 2'd1;
    logic [11:0]       mouse_xpos = '0;
    logic [11:0]       mouse_ypos = '0;
    logic              mouse_left = 1'b0;
    logic              mouse_right = 1'b0;
    logic [11:0]       board_xpos = 12'd100;
    logic [11:0]       board_ypos = 12'd100;
    logic [7:0]        button_size = 8'd40;
    logic [4:0]        button_num = 5'd8;
    logic [7:0][7:0]   mine_arr_easy = '0;
    logic [9:0][9:0]   mine_arr_medium = '0;
    logic [15:0][15:0] mine_arr_hard = '0;
    logic              game_won = 1'b0;
    logic [4:0]        symbol_ind_x;
    logic [4:0]        symbol_ind_y;
    logic              defuse;
    logic              mark_flag;
    logic              explode;
    logic              busy;

    click_action_decoder #(
        .POS_W     (12),
        .SIZE_W    (8),
        .MAX_CELLS (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .level           (level),
        .mouse_xpos      (mouse_xpos),
        .mouse_ypos      (mouse_ypos),
        .mouse_left      (mouse_left),
        .mouse_right     (mouse_right),
        .board_xpos      (board_xpos),
        .board_ypos      (board_ypos),
        .button_size     (button_size),
        .button_num      (button_num),
        .mine_arr_easy   (mine_arr_easy),
        .mine_arr_medium (mine_arr_medium),
        .mine_arr_hard   (mine_arr_hard),
        .game_won        (game_won),
        .symbol_ind_x    (symbol_ind_x),
        .symbol_ind_y    (symbol_ind_y),
        .defuse          (defuse),
        .mark_flag       (mark_flag),
        .explode         (explode),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // kind: 0 defuse, 1 mark_flag, 2 explode
    typedef struct {
        int kind;
        int x;
        int y;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every cycle showing any pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        int   pulses;
        pulses = {29'd0, explode, mark_flag, defuse};
        if (!rst && pulses != 0) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulses=%0d ind=(%0d,%0d), expected none (cycle %0d)",
                         pulses, symbol_ind_x, symbol_ind_y, cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", pulses, 1 << e.kind);
                chk("symbol_ind_x", int'(symbol_ind_x), e.x);
                chk("symbol_ind_y", int'(symbol_ind_y), e.y);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Press the given buttons at (x,y), queue the expected pulse (kind<0 means
    // none), hold briefly, release, then let the decoder settle.
    task automatic click(input bit l, input bit r, input int x, input int y,
                         input int kind, input int ex, input int ey, input int lat,
                         output bit saw_busy);
        exp_t e;
        saw_busy = 1'b0;
        @(negedge clk);
        mouse_xpos  = 12'(x);
        mouse_ypos  = 12'(y);
        mouse_left  = l;
        mouse_right = r;
        if (kind >= 0) begin
            e.kind = kind; e.x = ex; e.y = ey; e.cyc = cyc + lat;
            q.push_back(e);
        end
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            if (i == 2) begin
                mouse_left  = 1'b0;
                mouse_right = 1'b0;
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("outputs_in_reset", int'({busy, defuse, mark_flag, explode, symbol_ind_x, symbol_ind_y}), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit   sb;
        exp_t e;

        #1;
        chk("reset_outputs", int'({busy, defuse, mark_flag, explode, symbol_ind_x, symbol_ind_y}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Easy level, safe cell (2,3): defuse 6 cycles after the edge
        click(1, 0, 185, 230, 0, 2, 3, 6, sb);
        chk("busy_during_decode", int'(sb), 1);

        // Same cell mined: explode, then lockout
        mine_arr_easy[3][2] = 1'b1;
        click(1, 0, 185, 230, 2, 2, 3, 6, sb);
        click(1, 0, 105, 105, -1, 0, 0, 0, sb);
        chk("lockout_no_busy", int'(sb), 0);

        // Reset clears lockout
        reset_pulse();
        click(1, 0, 105, 105, 0, 0, 0, 3, sb);

        // Right click at last pixel of cell (0,0)
        click(0, 1, 139, 139, 1, 0, 0, 3, sb);

        // Simultaneous edges are ignored
        click(1, 1, 185, 230, -1, 0, 0, 0, sb);
        chk("both_edges_no_busy", int'(sb), 0);

        // Left of board
        click(1, 0, 90, 150, -1, 0, 0, 0, sb);
        chk("out_of_board_no_busy", int'(sb), 0);

        // idx_x reaches button_num: decode runs, then is dropped
        click(1, 0, 430, 150, -1, 0, 0, 0, sb);
        chk("oob_idx_was_busy", int'(sb), 1);
        chk("oob_idx_back_idle", int'(busy), 0);
        chk("oob_idx_holds_ind_x", int'(symbol_ind_x), 0);

        // Frozen by game_won, and by level 0
        game_won = 1'b1;
        click(1, 0, 185, 230, -1, 0, 0, 0, sb);
        chk("game_won_no_busy", int'(sb), 0);
        game_won = 1'b0;
        level = 2'd0;
        click(1, 0, 185, 230, -1, 0, 0, 0, sb);
        chk("level0_no_busy", int'(sb), 0);

        // Hard level, corner cell (15,15) mined; right edge during CALC dropped
        level       = 2'd3;
        button_size = 8'd20;
        button_num  = 5'd16;
        mine_arr_hard[15][15] = 1'b1;
        @(negedge clk);
        mouse_xpos = 12'd419;
        mouse_ypos = 12'd419;
        mouse_left = 1'b1;
        e.kind = 2; e.x = 15; e.y = 15; e.cyc = cyc + 18;
        q.push_back(e);
        repeat (4) @(negedge clk);
        chk("busy_in_calc", int'(busy), 1);
        mouse_right = 1'b1;
        repeat (25) @(negedge clk);
        mouse_left  = 1'b0;
        mouse_right = 1'b0;
        chk("hard_ind_hold_x", int'(symbol_ind_x), 15);
        reset_pulse();

        // Reset in the middle of CALC discards the click
        @(negedge clk);
        mouse_left = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midcalc_reset_outputs", int'({busy, defuse, mark_flag, explode, symbol_ind_x, symbol_ind_y}), 0);
        @(negedge clk);
        rst = 1'b0;
        mouse_left = 1'b0;
        repeat (30) @(negedge clk);

        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
